mem: RTL and testbench
======================

Name: mem

Overview:
- Memory-access pipeline stage that sits between execute and writeback.
- Registers the execute-stage outputs and performs the load or store against a data-memory request/ack interface. Stalls upstream while the access is outstanding.
- Presents writeback with pc, instr, dest_src, dest_reg and a result word. For completed loads the result is the extended load data and dest_src is rewritten from DEST_SRC_MEM to DEST_SRC_ALU, so writeback commits it.

Parameters:
- MAX_WAIT, 16: maximum number of request cycles without ack before the access is aborted with a fault.
- Widths ADDR_W, INSTR_W, WORD_W (32), REG_IDX_W and DEST_SRC_W come from config.vh. Encodings come from opcodes.vh.

Ports:
clk  in  1  clock; every register updates on the rising edge
clr  in  1  synchronous active-high reset
i_pc  in  ADDR_W  execute pc
i_instr  in  INSTR_W  execute instruction
i_dest_src  in  DEST_SRC_W  NONE/ALU/MEM
i_dest_reg  in  REG_IDX_W  destination register
i_alu_eval  in  WORD_W  ALU result; effective address for memory ops
i_mem_en  in  1  instruction is a load or store
i_mem_we  in  1  1 = store, 0 = load
i_mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
i_mem_unsigned  in  1  zero-extend loads
i_store_data  in  WORD_W  store source register value
o_stall  out  1  hold execute and earlier stages this cycle
o_fault  out  1  one-cycle pulse: misaligned access or timeout
o_dmem_req  out  1  data-memory request
o_dmem_we  out  1  write request
o_dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  WORD_W  lane-replicated store data
i_dmem_ack  in  1  access complete this cycle
i_dmem_rdata  in  WORD_W  read word; valid when ack is high
o_pc, o_instr, o_dest_src, o_dest_reg, o_alu_eval  out  same widths as inputs  to writeback

Behaviour:
- Stage registers r_* capture all i_* at each edge when o_stall = 0, and hold when o_stall = 1.
- clr dominates o_stall and forces on the next edge:
  - r_pc = 0, r_instr = 0, r_dest_reg = 0, r_alu_eval = 0, r_mem_en = 0
  - r_dest_src = DEST_SRC_NONE, state = ST_PASS, wait_cnt = 0
- All outputs are therefore 0 after reset, with o_dest_src = DEST_SRC_NONE.
- FSM ST_PASS / ST_ACCESS:
  - On a capture edge, next state is ST_ACCESS if the captured op has mem_en = 1 and is aligned; otherwise ST_PASS.
  - wait_cnt clears on every capture.
- ST_PASS:
  - o_dmem_req = 0, o_stall = 0.
  - Writeback outputs are the registers unchanged.
  - A misaligned captured op (half with addr[0] = 1, or word with addr[1:0] != 0) gives o_fault = 1 for that cycle, o_dest_src = NONE, and no request is issued.
- ST_ACCESS request fields:
  - o_dmem_req = 1, o_dmem_we = r_mem_we, o_dmem_addr = {r_alu_eval[ADDR_W-1:2], 2'b00}.
  - Byte: be = 0001 << a[1:0], wdata = {4{data[7:0]}}.
  - Half: be = 0011 << a[1:0], wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
  - Loads drive the same be.
- ST_ACCESS, i_dmem_ack = 1 (completion cycle):
  - o_stall = 0 and the next instruction is captured at this edge.
  - Store: o_dest_src = NONE.
  - Load: o_alu_eval = selected lane of i_dmem_rdata (byte a[1:0], half a[1]), sign-extended unless r_mem_unsigned; o_dest_src = ALU.
- ST_ACCESS, ack = 0:
  - If wait_cnt == MAX_WAIT-1: o_fault = 1, o_stall = 0, o_dest_src = NONE, and the stage advances.
  - Otherwise: o_stall = 1, o_dest_src = NONE (bubble to writeback), wait_cnt increments.
- Zero-wait memory (ack in the first request cycle) gives no stall cycles, so load-to-writeback throughput is 1 per cycle.
- i_dmem_ack in ST_PASS is ignored.
- clr during ST_ACCESS:
  - o_dmem_req remains combinationally asserted through the cycle in which clr is applied and is low after that edge.
  - No writeback occurs, and a late ack is ignored.
- Request fields are stable from the first request cycle until ack or abort.

Test Plan:
- ALU op passthrough: i_dest_src = ALU, dest_reg = 5, alu_eval = 0x1234 -> after 1 edge o_dest_src = ALU, o_dest_reg = 5, o_alu_eval = 0x1234, o_stall = 0, o_dmem_req = 0.
- Load byte signed, address 0x103, memory returns 0x80FF_0000 with ack after 3 cycles -> o_dmem_addr = 0x100, be = 1000, o_stall high for 3 cycles with o_dest_src = NONE, then o_alu_eval = 0xFFFF_FF80 and dest_src = ALU. Repeat unsigned -> 0x0000_0080.
- Store half, address 0x22, data 0xABCD, zero-wait ack -> be = 1100, wdata = 0xABCD_ABCD, we = 1, no stall, o_dest_src = NONE.
- Misaligned word load at 0x6 -> o_fault pulse 1 cycle, o_dmem_req never asserted, o_dest_src = NONE, no stall.
- Timeout with MAX_WAIT = 4 and no ack -> req high exactly 4 cycles, o_stall high for cycles 1-3, o_fault in cycle 4, pipeline resumes.
- clr asserted during the second wait cycle -> after that edge: req = 0, all outputs 0, dest_src = NONE, and an ack one cycle later produces no writeback.

Source files
------------

// File: rtl/mem.sv
// Memory-access pipeline stage between execute and writeback: registers the execute
// outputs, runs loads/stores over a req/ack data-memory port and stalls upstream until done.
module mem #(
  parameter int MAX_WAIT   = 16,
  parameter int ADDR_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int WORD_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int DEST_SRC_W = 2,
  parameter logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0,
  parameter logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1,
  parameter logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic                  i_mem_en,
  input  logic                  i_mem_we,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_unsigned,
  input  logic [WORD_W-1:0]     i_store_data,
  output logic                  o_stall,
  output logic                  o_fault,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_W-1:0]     o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [WORD_W-1:0]     o_dmem_wdata,
  input  logic                  i_dmem_ack,
  input  logic [WORD_W-1:0]     i_dmem_rdata,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_alu_eval
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic {ST_PASS, ST_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]      w_wait_cnt_nxt;
  logic                  w_capture;

  logic [ADDR_W-1:0]     r_pc;
  logic [INSTR_W-1:0]    r_instr;
  logic [DEST_SRC_W-1:0] r_dest_src;
  logic [REG_IDX_W-1:0]  r_dest_reg;
  logic [WORD_W-1:0]     r_alu_eval;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [1:0]            r_mem_size;
  logic                  r_mem_unsigned;
  logic [WORD_W-1:0]     r_store_data;

  logic                  w_r_aligned;
  logic                  w_i_aligned;

  // Bytes are always aligned; size 11 behaves as a word.
  function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~a[0];
      default: ok = (a == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [WORD_W-1:0] f_store_lanes(input logic [1:0] size,
                                                      input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] f_load_ext(input logic [WORD_W-1:0] rdata,
                                                   input logic [1:0] size,
                                                   input logic [1:0] a,
                                                   input logic uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] w;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: w = {{(WORD_W-8){~uns & b[7]}}, b};
      SZ_HALF: w = {{(WORD_W-16){~uns & h[15]}}, h};
      default: w = rdata;
    endcase
    return w;
  endfunction

  assign w_r_aligned = f_aligned(r_mem_size, r_alu_eval[1:0]);
  assign w_i_aligned = f_aligned(i_mem_size, i_alu_eval[1:0]);

  // Request fields come straight from the held stage registers, so they stay
  // stable for the whole access.
  assign o_dmem_we    = o_dmem_req & r_mem_we;
  assign o_dmem_addr  = {r_alu_eval[ADDR_W-1:2], 2'b00};
  assign o_dmem_be    = f_byte_en(r_mem_size, r_alu_eval[1:0]);
  assign o_dmem_wdata = f_store_lanes(r_mem_size, r_store_data);

  assign o_pc       = r_pc;
  assign o_instr    = r_instr;
  assign o_dest_reg = r_dest_reg;

  always_comb begin
    o_dmem_req = 1'b0;
    o_stall    = 1'b0;
    o_fault    = 1'b0;
    o_dest_src = r_dest_src;
    o_alu_eval = r_alu_eval;
    case (r_state)
      ST_PASS: begin
        if (r_mem_en && !w_r_aligned) begin
          o_fault    = 1'b1;
          o_dest_src = DEST_SRC_NONE;
        end
      end
      ST_ACCESS: begin
        o_dmem_req = 1'b1;
        if (i_dmem_ack) begin
          if (r_mem_we) begin
            o_dest_src = DEST_SRC_NONE;
          end else begin
            o_dest_src = DEST_SRC_ALU;
            o_alu_eval = f_load_ext(i_dmem_rdata, r_mem_size, r_alu_eval[1:0],
                                    r_mem_unsigned);
          end
        end else if (r_wait_cnt == CNT_LAST) begin
          o_fault    = 1'b1;
          o_dest_src = DEST_SRC_NONE;
        end else begin
          o_stall    = 1'b1;
          o_dest_src = DEST_SRC_NONE;
        end
      end
      default: ;
    endcase
  end

  assign w_capture = ~o_stall;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_capture) begin
      w_state_nxt    = (i_mem_en && w_i_aligned) ? ST_ACCESS : ST_PASS;
      w_wait_cnt_nxt = '0;
    end else begin
      w_wait_cnt_nxt = r_wait_cnt + 1'b1;
    end
  end

  // Stage boundary: control and writeback-visible registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_PASS;
      r_wait_cnt <= '0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_dest_src <= DEST_SRC_NONE;
      r_dest_reg <= '0;
      r_alu_eval <= '0;
      r_mem_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_pc       <= i_pc;
        r_instr    <= i_instr;
        r_dest_src <= i_dest_src;
        r_dest_reg <= i_dest_reg;
        r_alu_eval <= i_alu_eval;
        r_mem_en   <= i_mem_en;
      end
    end
  end

  // Access qualifiers are only meaningful while r_mem_en is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_we       <= i_mem_we;
      r_mem_size     <= i_mem_size;
      r_mem_unsigned <= i_mem_unsigned;
      r_store_data   <= i_store_data;
    end
  end

endmodule

// File: tb/tb_mem.sv
// Directed bench for the mem stage: vector table of single-access ops plus
// sequences for wait states, timeout and reset during an access.
module tb_mem;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] i_pc, i_instr, i_alu_eval, i_store_data, i_dmem_rdata;
  logic [1:0]  i_dest_src, i_mem_size;
  logic [4:0]  i_dest_reg;
  logic        i_mem_en, i_mem_we, i_mem_unsigned, i_dmem_ack;
  logic        o_stall, o_fault, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_pc, o_instr, o_alu_eval;
  logic [3:0]  o_dmem_be;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;

  int n_checks = 0;
  int n_err = 0;

  mem #(.MAX_WAIT(4)) dut (
    .clk(clk), .clr(clr),
    .i_pc(i_pc), .i_instr(i_instr), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .i_alu_eval(i_alu_eval), .i_mem_en(i_mem_en), .i_mem_we(i_mem_we),
    .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned), .i_store_data(i_store_data),
    .o_stall(o_stall), .o_fault(o_fault), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg),
    .o_alu_eval(o_alu_eval)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  dsrc;
    logic [4:0]  dreg;
    logic [31:0] alu;
    logic        en;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] sdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic [1:0]  e_dsrc;
    logic [31:0] e_alu;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    i_pc = 32'h0; i_instr = 32'h0; i_dest_src = 2'd0; i_dest_reg = 5'd0;
    i_alu_eval = 32'h0; i_mem_en = 1'b0; i_mem_we = 1'b0; i_mem_size = 2'b00;
    i_mem_unsigned = 1'b0; i_store_data = 32'h0;
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [1:0] dsrc, input logic [4:0] dreg,
                          input logic [31:0] alu, input logic en, input logic we,
                          input logic [1:0] sz, input logic uns, input logic [31:0] sdata);
    i_pc = pc; i_instr = pc ^ 32'h0000_0013; i_dest_src = dsrc; i_dest_reg = dreg;
    i_alu_eval = alu; i_mem_en = en; i_mem_we = we; i_mem_size = sz;
    i_mem_unsigned = uns; i_store_data = sdata;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte_wait3(input logic uns, input logic [31:0] exp_alu, input string tag);
    drive_op(32'h200, 2'd2, 5'd9, 32'h103, 1'b1, 1'b0, 2'b00, uns, 32'h0);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk({tag, "_wait_req"}, {31'b0, o_dmem_req}, 32'd1);
      chk({tag, "_wait_stall"}, {31'b0, o_stall}, 32'd1);
      chk({tag, "_wait_dsrc"}, {30'b0, o_dest_src}, 32'd0);
      chk({tag, "_addr"}, o_dmem_addr, 32'h100);
      chk({tag, "_be"}, {28'b0, o_dmem_be}, 32'h8);
      step();
    end
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h80FF_0000;
    #1;
    chk({tag, "_done_stall"}, {31'b0, o_stall}, 32'd0);
    chk({tag, "_done_alu"}, o_alu_eval, exp_alu);
    chk({tag, "_done_dsrc"}, {30'b0, o_dest_src}, 32'd1);
    chk({tag, "_done_dreg"}, {27'b0, o_dest_reg}, 32'd9);
    step();
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
  endtask

  initial begin
    // pc  dsrc dreg alu en we sz uns sdata ack rdata | req we be addr wdata fault dsrc alu
    vecs[0]  = '{32'h10, 2'd1, 5'd5, 32'h1234, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 32'h1234};
    vecs[1]  = '{32'h14, 2'd2, 5'd6, 32'h101, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 32'h11223344,
                 1'b1, 1'b0, 4'b0010, 32'h100, 32'h0, 1'b0, 2'd1, 32'h33};
    vecs[2]  = '{32'h18, 2'd2, 5'd7, 32'h202, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h00850000,
                 1'b1, 1'b0, 4'b0100, 32'h200, 32'h0, 1'b0, 2'd1, 32'hFFFFFF85};
    vecs[3]  = '{32'h1C, 2'd2, 5'd8, 32'h12, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 32'h9ABC1234,
                 1'b1, 1'b0, 4'b1100, 32'h10, 32'h0, 1'b0, 2'd1, 32'hFFFF9ABC};
    vecs[4]  = '{32'h20, 2'd2, 5'd9, 32'h10, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 1'b1, 32'h9ABC8001,
                 1'b1, 1'b0, 4'b0011, 32'h10, 32'h0, 1'b0, 2'd1, 32'h8001};
    vecs[5]  = '{32'h24, 2'd2, 5'd10, 32'h44, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D,
                 1'b1, 1'b0, 4'b1111, 32'h44, 32'h0, 1'b0, 2'd1, 32'hCAFEF00D};
    vecs[6]  = '{32'h28, 2'd0, 5'd0, 32'h22, 1'b1, 1'b1, 2'b01, 1'b0, 32'h1234ABCD, 1'b1, 32'h0,
                 1'b1, 1'b1, 4'b1100, 32'h20, 32'hABCDABCD, 1'b0, 2'd0, 32'h22};
    vecs[7]  = '{32'h2C, 2'd0, 5'd0, 32'h3, 1'b1, 1'b1, 2'b00, 1'b0, 32'h000000A5, 1'b1, 32'h0,
                 1'b1, 1'b1, 4'b1000, 32'h0, 32'hA5A5A5A5, 1'b0, 2'd0, 32'h3};
    vecs[8]  = '{32'h30, 2'd0, 5'd0, 32'h8, 1'b1, 1'b1, 2'b11, 1'b0, 32'h01020304, 1'b1, 32'h0,
                 1'b1, 1'b1, 4'b1111, 32'h8, 32'h01020304, 1'b0, 2'd0, 32'h8};
    vecs[9]  = '{32'h34, 2'd2, 5'd11, 32'h6, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h6};
    vecs[10] = '{32'h38, 2'd2, 5'd12, 32'h31, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h31};

    idle();
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    #1;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_alu", o_alu_eval, 32'h0);
    chk("rst_dreg", {27'b0, o_dest_reg}, 32'h0);
    chk("rst_dsrc", {30'b0, o_dest_src}, 32'h0);
    chk("rst_ctl", {29'b0, o_stall, o_fault, o_dmem_req}, 32'h0);

    for (int v = 0; v < 11; v++) begin
      @(posedge clk); #1;
      drive_op(vecs[v].pc, vecs[v].dsrc, vecs[v].dreg, vecs[v].alu, vecs[v].en, vecs[v].we,
               vecs[v].sz, vecs[v].uns, vecs[v].sdata);
      step();
      idle();
      i_dmem_ack = vecs[v].ack; i_dmem_rdata = vecs[v].rdata;
      #1;
      chk($sformatf("v%0d_req", v), {31'b0, o_dmem_req}, {31'b0, vecs[v].e_req});
      chk($sformatf("v%0d_stall", v), {31'b0, o_stall}, 32'd0);
      chk($sformatf("v%0d_fault", v), {31'b0, o_fault}, {31'b0, vecs[v].e_fault});
      chk($sformatf("v%0d_dsrc", v), {30'b0, o_dest_src}, {30'b0, vecs[v].e_dsrc});
      chk($sformatf("v%0d_alu", v), o_alu_eval, vecs[v].e_alu);
      chk($sformatf("v%0d_pc", v), o_pc, vecs[v].pc);
      chk($sformatf("v%0d_dreg", v), {27'b0, o_dest_reg}, {27'b0, vecs[v].dreg});
      if (vecs[v].e_req) begin
        chk($sformatf("v%0d_we", v), {31'b0, o_dmem_we}, {31'b0, vecs[v].e_we});
        chk($sformatf("v%0d_be", v), {28'b0, o_dmem_be}, {28'b0, vecs[v].e_be});
        chk($sformatf("v%0d_addr", v), o_dmem_addr, vecs[v].e_addr);
        if (vecs[v].e_we)
          chk($sformatf("v%0d_wdata", v), o_dmem_wdata, vecs[v].e_wdata);
      end
      step();
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
      #1;
      chk($sformatf("v%0d_after_fault", v), {31'b0, o_fault}, 32'd0);
      chk($sformatf("v%0d_after_req", v), {31'b0, o_dmem_req}, 32'd0);
    end

    @(posedge clk); #1;
    load_byte_wait3(1'b0, 32'hFFFF_FF80, "lbs");
    load_byte_wait3(1'b1, 32'h0000_0080, "lbu");

    // Timeout: no ack for MAX_WAIT request cycles; an ALU op waits upstream.
    drive_op(32'h300, 2'd2, 5'd3, 32'h40, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    step();
    drive_op(32'h304, 2'd1, 5'd7, 32'h77, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("to_c%0d_req", c), {31'b0, o_dmem_req}, 32'd1);
      chk($sformatf("to_c%0d_stall", c), {31'b0, o_stall}, (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_c%0d_fault", c), {31'b0, o_fault}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_c%0d_dsrc", c), {30'b0, o_dest_src}, 32'd0);
      step();
    end
    idle();
    #1;
    chk("to_resume_req", {31'b0, o_dmem_req}, 32'd0);
    chk("to_resume_fault", {31'b0, o_fault}, 32'd0);
    chk("to_resume_dsrc", {30'b0, o_dest_src}, 32'd1);
    chk("to_resume_alu", o_alu_eval, 32'h77);
    chk("to_resume_dreg", {27'b0, o_dest_reg}, 32'd7);

    // Reset in the second wait cycle, then a late ack.
    step();
    drive_op(32'h400, 2'd2, 5'd4, 32'h80, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    step();
    idle();
    #1;
    chk("clr_w1_stall", {31'b0, o_stall}, 32'd1);
    step();
    clr = 1'b1;
    #1;
    chk("clr_w2_req", {31'b0, o_dmem_req}, 32'd1);
    step();
    clr = 1'b0;
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("clr_after_req", {31'b0, o_dmem_req}, 32'd0);
    chk("clr_after_dsrc", {30'b0, o_dest_src}, 32'd0);
    chk("clr_after_pc", o_pc, 32'h0);
    chk("clr_after_alu", o_alu_eval, 32'h0);
    chk("clr_after_dreg", {27'b0, o_dest_reg}, 32'h0);
    chk("clr_after_ctl", {30'b0, o_stall, o_fault}, 32'h0);
    step();
    i_dmem_ack = 1'b0;
    #1;
    chk("clr_late_dsrc", {30'b0, o_dest_src}, 32'd0);
    chk("clr_late_alu", o_alu_eval, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
